// File: rtl/ysyx_24100006_xbar.sv
// AXI-Lite 1-master/2-slave crossbar: slave 0 = memory window, slave 1 = CLINT mtime.
// Unmapped addresses get DECERR locally; one transaction in flight at a time.
//   state   | meaning
//   IDLE    | waiting for a request, decode latched on acceptance
//   RD_ADDR | ar forwarded to selected slave
//   RD_DATA | r passed through from selected slave
//   RD_ERR  | unmapped read, local DECERR response
//   WR      | aw and w forwarded independently
//   WR_RESP | b passed through from selected slave
//   WR_ERR  | unmapped write, local DECERR response
module ysyx_24100006_xbar #(
  parameter logic [31:0] MEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE   = 32'h0800_0000,
  parameter logic [31:0] CLINT_BASE = 32'ha000_0048,
  parameter logic [31:0] CLINT_SIZE = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_araddr,
  input  logic        m_arvalid,
  output logic        m_arready,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  output logic        m_rvalid,
  input  logic        m_rready,
  input  logic [31:0] m_awaddr,
  input  logic        m_awvalid,
  output logic        m_awready,
  input  logic [31:0] m_wdata,
  input  logic [7:0]  m_wstrb,
  input  logic        m_wvalid,
  output logic        m_wready,
  output logic [1:0]  m_bresp,
  output logic        m_bvalid,
  input  logic        m_bready,
  output logic [63:0] s_araddr,
  output logic [63:0] s_awaddr,
  output logic [63:0] s_wdata,
  output logic [15:0] s_wstrb,
  output logic [1:0]  s_arvalid,
  output logic [1:0]  s_awvalid,
  output logic [1:0]  s_wvalid,
  output logic [1:0]  s_rready,
  output logic [1:0]  s_bready,
  input  logic [1:0]  s_arready,
  input  logic [1:0]  s_awready,
  input  logic [1:0]  s_wready,
  input  logic [1:0]  s_rvalid,
  input  logic [1:0]  s_bvalid,
  input  logic [63:0] s_rdata,
  input  logic [3:0]  s_rresp,
  input  logic [3:0]  s_bresp
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] RD_ERR  = 3'd3;
  localparam logic [2:0] WR      = 3'd4;
  localparam logic [2:0] WR_RESP = 3'd5;
  localparam logic [2:0] WR_ERR  = 3'd6;

  logic [2:0]  state;
  logic [31:0] addr_q;
  logic        sel;
  logic        err;
  logic        aw_done;
  logic        w_done;
  logic        acc_done;

  // 33-bit compare so a window ending exactly at 2^32 does not wrap
  function automatic logic in_win(input logic [31:0] a, input logic [31:0] base,
                                  input logic [31:0] size);
    return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < ({1'b0, base} + {1'b0, size}));
  endfunction

  logic [31:0] dec_addr;
  logic        dec_clint;
  logic        dec_err;

  always_comb begin
    dec_addr  = m_arvalid ? m_araddr : m_awaddr;
    dec_clint = in_win(dec_addr, CLINT_BASE, CLINT_SIZE);
    dec_err   = !in_win(dec_addr, MEM_BASE, MEM_SIZE) && !dec_clint;
  end

  logic aw_hs;
  logic w_hs;

  always_comb begin
    s_araddr  = {addr_q, addr_q};
    s_awaddr  = {addr_q, addr_q};
    s_wdata   = {m_wdata, m_wdata};
    s_wstrb   = {m_wstrb, m_wstrb};
    s_arvalid = 2'b00;
    s_awvalid = 2'b00;
    s_wvalid  = 2'b00;
    s_rready  = 2'b00;
    s_bready  = 2'b00;
    m_arready = 1'b0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = 32'h0;
    m_rresp   = 2'b00;
    m_bvalid  = 1'b0;
    m_bresp   = 2'b00;
    case (state)
      RD_ADDR: begin
        s_arvalid[sel] = m_arvalid;
        m_arready      = s_arready[sel];
      end
      RD_DATA: begin
        m_rvalid      = s_rvalid[sel];
        m_rdata       = sel ? s_rdata[63:32] : s_rdata[31:0];
        m_rresp       = sel ? s_rresp[3:2] : s_rresp[1:0];
        s_rready[sel] = m_rready;
      end
      RD_ERR: begin
        m_arready = !acc_done;
        m_rvalid  = acc_done && err;
        m_rresp   = (acc_done && err) ? 2'b11 : 2'b00;
      end
      WR: begin
        s_awvalid[sel] = m_awvalid && !aw_done;
        m_awready      = s_awready[sel] && !aw_done;
        s_wvalid[sel]  = m_wvalid && !w_done;
        m_wready       = s_wready[sel] && !w_done;
      end
      WR_RESP: begin
        m_bvalid      = s_bvalid[sel];
        m_bresp       = sel ? s_bresp[3:2] : s_bresp[1:0];
        s_bready[sel] = m_bready;
      end
      WR_ERR: begin
        // aw and w are only taken as a pair
        m_awready = !acc_done && m_awvalid && m_wvalid;
        m_wready  = !acc_done && m_awvalid && m_wvalid;
        m_bvalid  = acc_done && err;
        m_bresp   = (acc_done && err) ? 2'b11 : 2'b00;
      end
      default: ;
    endcase
  end

  always_comb begin
    aw_hs = m_awvalid && m_awready;
    w_hs  = m_wvalid && m_wready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= 32'h0;
      sel      <= 1'b0;
      err      <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      acc_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          aw_done  <= 1'b0;
          w_done   <= 1'b0;
          acc_done <= 1'b0;
          if (m_arvalid) begin
            addr_q <= m_araddr;
            sel    <= dec_clint;
            err    <= dec_err;
            state  <= dec_err ? RD_ERR : RD_ADDR;
          end else if (m_awvalid && m_wvalid) begin
            addr_q <= m_awaddr;
            sel    <= dec_clint;
            err    <= dec_err;
            state  <= dec_err ? WR_ERR : WR;
          end
        end
        RD_ADDR: if (m_arvalid && s_arready[sel]) state <= RD_DATA;
        RD_DATA: if (s_rvalid[sel] && m_rready) state <= IDLE;
        RD_ERR: begin
          if (!acc_done && m_arvalid) acc_done <= 1'b1;
          if (acc_done && m_rready) begin
            acc_done <= 1'b0;
            state    <= IDLE;
          end
        end
        WR: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_RESP;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WR_RESP: if (s_bvalid[sel] && m_bready) state <= IDLE;
        WR_ERR: begin
          if (!acc_done && m_awvalid && m_wvalid) acc_done <= 1'b1;
          if (acc_done && m_bready) begin
            acc_done <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_xbar.sv
// Directed bench for ysyx_24100006_xbar with a small memory slave and a fixed-mtime CLINT slave.
module tb_ysyx_24100006_xbar;

  localparam int          LAT0     = 1;
  localparam int          LAT1     = 2;
  localparam int          TMO      = 60;
  localparam logic [31:0] MTIME_LO = 32'h2345_6789;
  localparam logic [31:0] MTIME_HI = 32'h0000_0001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_rresp, m_bresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [7:0]  m_wstrb;
  logic [63:0] s_araddr, s_awaddr, s_wdata, s_rdata;
  logic [15:0] s_wstrb;
  logic [1:0]  s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;
  logic [1:0]  s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
  logic [3:0]  s_rresp, s_bresp;

  assign s_arready = 2'b11;
  assign s_awready = 2'b11;
  assign s_wready  = 2'b11;
  assign s_rresp   = 4'b0000;
  assign s_bresp   = 4'b0000;

  ysyx_24100006_xbar dut (
    .clk(clk), .reset(reset),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_arvalid(s_arvalid), .s_awvalid(s_awvalid), .s_wvalid(s_wvalid),
    .s_rready(s_rready), .s_bready(s_bready),
    .s_arready(s_arready), .s_awready(s_awready), .s_wready(s_wready),
    .s_rvalid(s_rvalid), .s_bvalid(s_bvalid),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_bresp(s_bresp)
  );

  // slave models: 0 = 16-word memory, 1 = CLINT with frozen mtime
  logic [31:0] mem [16];
  logic [1:0]  rd_pend, wa_got, wd_got;
  int          rd_cnt [2];
  logic [31:0] rd_addr [2];
  logic [31:0] last_awaddr0;

  function automatic logic [31:0] slave_word(input int i, input logic [31:0] a);
    if (i == 0) return mem[a[5:2]];
    return a[2] ? MTIME_HI : MTIME_LO;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        rd_pend[i]  <= 1'b0;
        s_rvalid[i] <= 1'b0;
        s_bvalid[i] <= 1'b0;
        wa_got[i]   <= 1'b0;
        wd_got[i]   <= 1'b0;
      end else begin
        if (s_rvalid[i] && s_rready[i]) s_rvalid[i] <= 1'b0;
        if (s_arvalid[i] && s_arready[i]) begin
          rd_pend[i] <= 1'b1;
          rd_cnt[i]  <= (i == 0) ? LAT0 : LAT1;
          rd_addr[i] <= s_araddr[i*32 +: 32];
        end else if (rd_pend[i]) begin
          if (rd_cnt[i] == 0) begin
            rd_pend[i]          <= 1'b0;
            s_rvalid[i]         <= 1'b1;
            s_rdata[i*32 +: 32] <= slave_word(i, rd_addr[i]);
          end else begin
            rd_cnt[i] <= rd_cnt[i] - 1;
          end
        end
        if (s_bvalid[i] && s_bready[i]) s_bvalid[i] <= 1'b0;
        if (s_awvalid[i] && s_awready[i]) begin
          wa_got[i] <= 1'b1;
          if (i == 0) last_awaddr0 <= s_awaddr[31:0];
        end
        if (s_wvalid[i] && s_wready[i]) wd_got[i] <= 1'b1;
        if ((wa_got[i] || (s_awvalid[i] && s_awready[i])) &&
            (wd_got[i] || (s_wvalid[i] && s_wready[i]))) begin
          s_bvalid[i] <= 1'b1;
          wa_got[i]   <= 1'b0;
          wd_got[i]   <= 1'b0;
        end
      end
    end
    if (reset) begin
      for (int j = 0; j < 16; j++) mem[j] <= 32'h5555_5555;
    end else if (s_wvalid[0] && s_wready[0]) begin
      for (int b = 0; b < 4; b++)
        if (s_wstrb[b]) mem[s_awaddr[5:2]][b*8 +: 8] <= s_wdata[b*8 +: 8];
    end
  end

  int  n_cmp = 0;
  int  n_bad = 0;
  time t_rd_done, t_aw_first;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int stall,
                         output logic [31:0] d, output logic [1:0] r, output int lat,
                         output int ar_first, output logic [1:0] ar_or,
                         output logic [1:0] w_or, output bit stable, output int held);
    bit hs_ar, hs_r, done;
    int n;
    d = 32'h0; r = 2'b00; lat = -1; ar_first = -1; ar_or = 2'b00; w_or = 2'b00;
    stable = 1'b1; held = 0; done = 1'b0; n = 0;
    m_araddr  = a;
    m_arvalid = 1'b1;
    m_rready  = (stall == 0);
    while (!done && n < TMO) begin
      #1;
      ar_or |= s_arvalid;
      w_or  |= s_awvalid | s_wvalid;
      if (|s_arvalid && ar_first < 0) ar_first = n;
      if (m_rvalid) begin
        if (lat < 0) begin
          lat = n; d = m_rdata; r = m_rresp;
        end else if (m_rdata !== d) begin
          stable = 1'b0;
        end
        if (!m_rready) held++;
      end
      hs_ar = m_arvalid && m_arready;
      hs_r  = m_rvalid && m_rready;
      @(posedge clk);
      #1;
      n++;
      if (hs_ar) m_arvalid = 1'b0;
      if (hs_r) begin
        done = 1'b1;
        m_rready = 1'b0;
        t_rd_done = $time;
      end else if (lat >= 0 && held >= stall) begin
        m_rready = 1'b1;
      end
    end
    m_arvalid = 1'b0;
    check_val("rd_done", done, 1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [7:0] ws,
                          output logic [1:0] b, output logic [1:0] aw_or,
                          output logic [1:0] w_or, output logic [1:0] ar_or,
                          output logic [31:0] wd_obs);
    bit hs_aw, hs_w, hs_b, done;
    int n;
    b = 2'b00; aw_or = 2'b00; w_or = 2'b00; ar_or = 2'b00; wd_obs = 32'h0;
    done = 1'b0; n = 0;
    m_awaddr = a; m_wdata = wd; m_wstrb = ws;
    m_awvalid = 1'b1; m_wvalid = 1'b1; m_bready = 1'b1;
    while (!done && n < TMO) begin
      #1;
      aw_or |= s_awvalid;
      w_or  |= s_wvalid;
      ar_or |= s_arvalid;
      if (|s_awvalid && t_aw_first == 0) t_aw_first = $time;
      if (|s_wvalid) wd_obs = s_wdata[31:0];
      if (m_bvalid) b = m_bresp;
      hs_aw = m_awvalid && m_awready;
      hs_w  = m_wvalid && m_wready;
      hs_b  = m_bvalid && m_bready;
      @(posedge clk);
      #1;
      n++;
      if (hs_aw) m_awvalid = 1'b0;
      if (hs_w)  m_wvalid  = 1'b0;
      if (hs_b) begin
        done = 1'b1;
        m_bready = 1'b0;
      end
    end
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    check_val("wr_done", done, 1);
  endtask

  logic [31:0] d, wd_obs;
  logic [1:0]  r, b, ar_or, aw_or, w_or, x_or;
  int          lat, ar_first, held;
  bit          stable, ok;

  initial begin
    reset = 1'b1;
    m_araddr = 32'h0; m_arvalid = 1'b0; m_rready = 1'b0;
    m_awaddr = 32'h0; m_awvalid = 1'b0; m_wdata = 32'h0; m_wstrb = 8'h0;
    m_wvalid = 1'b0; m_bready = 1'b0;
    t_rd_done = 0; t_aw_first = 0;
    repeat (3) @(posedge clk);
    #1;
    m_arvalid = 1'b1; m_awvalid = 1'b1; m_wvalid = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_m_hs", {m_arready, m_awready, m_wready, m_rvalid, m_bvalid}, 5'b0);
    check_val("rst_s_hs", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 10'b0);
    check_val("rst_resp", {m_rdata, m_rresp, m_bresp}, 36'h0);
    m_arvalid = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0;
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;

    // CLINT low word read: ar seen by slave one cycle late, slave latency LAT1+2 edges
    do_read(32'ha000_0048, 0, d, r, lat, ar_first, ar_or, x_or, stable, held);
    check_val("t1_rdata", d, MTIME_LO);
    check_val("t1_rresp", r, 2'b00);
    check_val("t1_arvalid", ar_or, 2'b10);
    check_val("t1_ar_first", ar_first, 1);
    check_val("t1_latency", lat, LAT1 + 3);
    check_val("t1_no_wr", x_or, 2'b00);

    do_write(32'h8000_0010, 32'hdead_beef, 8'h0f, b, aw_or, w_or, ar_or, wd_obs);
    check_val("t2_bresp", b, 2'b00);
    check_val("t2_awvalid", aw_or, 2'b01);
    check_val("t2_wvalid", w_or, 2'b01);
    check_val("t2_no_ar", ar_or, 2'b00);
    check_val("t2_s_wdata", wd_obs, 32'hdead_beef);
    check_val("t2_s_awaddr", last_awaddr0, 32'h8000_0010);

    do_write(32'h8000_0014, 32'hcafe_f00d, 8'h03, b, aw_or, w_or, ar_or, wd_obs);
    check_val("strb_bresp", b, 2'b00);
    do_read(32'h8000_0014, 0, d, r, lat, ar_first, ar_or, x_or, stable, held);
    check_val("strb_rdata", d, 32'h5555_f00d);
    check_val("strb_arvalid", ar_or, 2'b01);

    do_read(32'h1000_0000, 0, d, r, lat, ar_first, ar_or, x_or, stable, held);
    check_val("t3_rresp", r, 2'b11);
    check_val("t3_rdata", d, 32'h0);
    check_val("t3_no_ar", ar_or, 2'b00);
    do_write(32'h1000_0000, 32'h1111_2222, 8'h0f, b, aw_or, w_or, ar_or, wd_obs);
    check_val("t3_bresp", b, 2'b11);
    check_val("t3_no_aw_w", {aw_or, w_or}, 4'b0000);

    // window edges
    do_read(32'h87ff_fffc, 0, d, r, lat, ar_first, ar_or, x_or, stable, held);
    check_val("mem_top_resp", {r, ar_or}, 4'b0001);
    check_val("mem_top_data", d, 32'h5555_5555);
    do_read(32'h8800_0000, 0, d, r, lat, ar_first, ar_or, x_or, stable, held);
    check_val("mem_end_resp", {r, ar_or}, 4'b1100);
    do_read(32'h7fff_fffc, 0, d, r, lat, ar_first, ar_or, x_or, stable, held);
    check_val("mem_below_resp", {r, ar_or}, 4'b1100);
    do_read(32'ha000_0044, 0, d, r, lat, ar_first, ar_or, x_or, stable, held);
    check_val("clint_below_resp", {r, ar_or}, 4'b1100);
    do_read(32'ha000_0050, 0, d, r, lat, ar_first, ar_or, x_or, stable, held);
    check_val("clint_end_resp", {r, ar_or}, 4'b1100);

    t_aw_first = 0;
    fork
      do_read(32'ha000_0048, 0, d, r, lat, ar_first, ar_or, x_or, stable, held);
      do_write(32'h8000_0018, 32'h1234_5678, 8'h0f, b, aw_or, w_or, x_or, wd_obs);
    join
    check_val("t4_rdata", d, MTIME_LO);
    check_val("t4_bresp", b, 2'b00);
    check_val("t4_order", (t_aw_first > t_rd_done), 1);
    check_val("t4_awvalid", aw_or, 2'b01);

    do_read(32'h8000_0010, 5, d, r, lat, ar_first, ar_or, x_or, stable, held);
    check_val("t5_rdata", d, 32'hdead_beef);
    check_val("t5_stable", stable, 1);
    check_val("t5_held", held, 5);
    check_val("t5_rresp", r, 2'b00);

    m_araddr = 32'h8000_0000; m_arvalid = 1'b1; m_rready = 1'b0; ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (m_arready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    m_arvalid = 1'b0;
    check_val("t6_ar_hs", ok, 1);
    @(posedge clk);
    #1;
    reset = 1'b1; m_arvalid = 1'b1; m_rready = 1'b1;
    @(posedge clk);
    #2;
    check_val("t6_m_hs", {m_arready, m_awready, m_wready, m_rvalid, m_bvalid}, 5'b0);
    check_val("t6_s_hs", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 10'b0);
    m_arvalid = 1'b0; m_rready = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_read(32'ha000_004c, 0, d, r, lat, ar_first, ar_or, x_or, stable, held);
    check_val("t6_mtime_hi", d, MTIME_HI);
    check_val("t6_rresp", r, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
